// File: rtl/touch_scan_sched_if.sv
// Conversion request/response bus between the touch scan scheduler (master)
// and the ADC conversion engine (slave).
interface touch_scan_sched_if;
    logic        convStart;
    logic        convCh;
    logic        convDone;
    logic [11:0] convData;

    modport master (
        output convStart,
        output convCh,
        input  convDone,
        input  convData
    );

    modport slave (
        input  convStart,
        input  convCh,
        output convDone,
        output convData
    );
endinterface

// File: rtl/touch_scan_sched.sv
// Touch-screen scan scheduler: debounces the pen interrupt, then alternates
// X/Y conversion requests, averages 2^AVG_LOG2 sample pairs per reported
// coordinate, and aborts a round when the conversion engine stops answering.
// SETTLE_CYCLES and TIMEOUT_CYCLES are expected to be at least 1.
module touch_scan_sched #(
    parameter int AVG_LOG2       = 2,
    parameter int SETTLE_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_penIrqN,
    touch_scan_sched_if.master        conv,
    output logic [11:0]               o_xCoord,
    output logic [11:0]               o_yCoord,
    output logic                      o_coordValid,
    output logic                      o_penDown,
    output logic                      o_convErr
);

    localparam int ACC_W     = 12 + AVG_LOG2;
    localparam int PAIR_W    = AVG_LOG2 + 1;
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PAIR_W-1:0]    PAIR_LAST    = PAIR_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_REQ_X,
        S_WAIT_X,
        S_REQ_Y,
        S_WAIT_Y,
        S_ROUND_END
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [1:0]            r_sync;
    logic [SETTLE_W-1:0]   r_settleCnt;
    logic [TIMEOUT_W-1:0]  r_timeoutCnt;
    logic [PAIR_W-1:0]     r_pairCnt;
    logic [ACC_W-1:0]      r_accX;
    logic [ACC_W-1:0]      r_accY;
    logic [11:0]           r_xCoord;
    logic [11:0]           r_yCoord;
    logic                  r_coordValid;
    logic                  r_penDown;
    logic                  r_convErr;

    logic                  w_penS;
    logic                  w_settleDone;
    logic                  w_timeout;
    logic                  w_lastPair;
    logic [ACC_W-1:0]      w_dataExt;
    logic [ACC_W-1:0]      w_sumY;
    logic [11:0]           w_avgX;
    logic [11:0]           w_avgY;

    // Pen is "down" when the synchronized active-low interrupt reads low.
    assign w_penS       = ~r_sync[1];
    assign w_settleDone = (r_settleCnt == SETTLE_LAST);
    assign w_timeout    = (r_timeoutCnt == TIMEOUT_LAST);
    assign w_lastPair   = (r_pairCnt == PAIR_LAST);
    assign w_dataExt    = ACC_W'(conv.convData);
    // The final Y sample is folded in directly so the average is ready one
    // cycle after the last conversion completes.
    assign w_sumY       = r_accY + w_dataExt;
    assign w_avgX       = 12'(r_accX >> AVG_LOG2);
    assign w_avgY       = 12'(w_sumY >> AVG_LOG2);

    assign o_xCoord     = r_xCoord;
    assign o_yCoord     = r_yCoord;
    assign o_coordValid = r_coordValid;
    assign o_penDown    = r_penDown;
    assign o_convErr    = r_convErr;

    // State register for the scan sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection plus the request strobes, which follow the REQ states directly.
    always_comb begin
        w_nextState    = r_state;
        conv.convStart = 1'b0;
        conv.convCh    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_penS) w_nextState = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (!w_penS)           w_nextState = S_IDLE;
                else if (w_settleDone) w_nextState = S_REQ_X;
            end
            S_REQ_X: begin
                conv.convStart = 1'b1;
                w_nextState    = S_WAIT_X;
            end
            S_WAIT_X: begin
                if (conv.convDone) w_nextState = S_REQ_Y;
                else if (w_timeout) w_nextState = S_IDLE;
            end
            S_REQ_Y: begin
                conv.convStart = 1'b1;
                conv.convCh    = 1'b1;
                w_nextState    = S_WAIT_Y;
            end
            S_WAIT_Y: begin
                if (conv.convDone) w_nextState = S_ROUND_END;
                else if (w_timeout) w_nextState = S_IDLE;
            end
            S_ROUND_END: begin
                w_nextState = w_penS ? S_REQ_X : S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Synchronizer, counters, accumulators and the registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= '0;
            r_settleCnt  <= '0;
            r_timeoutCnt <= '0;
            r_pairCnt    <= '0;
            r_accX       <= '0;
            r_accY       <= '0;
            r_xCoord     <= '0;
            r_yCoord     <= '0;
            r_coordValid <= 1'b0;
            r_penDown    <= 1'b0;
            r_convErr    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], i_penIrqN};
            r_coordValid <= 1'b0;
            r_convErr    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_settleCnt <= '0;
                end
                S_DEBOUNCE: begin
                    if (w_penS && !w_settleDone) begin
                        r_settleCnt <= r_settleCnt + SETTLE_W'(1);
                    end else if (w_penS && w_settleDone) begin
                        r_penDown <= 1'b1;
                        r_accX    <= '0;
                        r_accY    <= '0;
                        r_pairCnt <= '0;
                    end
                end
                S_REQ_X, S_REQ_Y: begin
                    r_timeoutCnt <= '0;
                end
                S_WAIT_X: begin
                    if (conv.convDone) begin
                        r_accX <= r_accX + w_dataExt;
                    end else if (w_timeout) begin
                        r_convErr <= 1'b1;
                        r_penDown <= 1'b0;
                        r_accX    <= '0;
                        r_accY    <= '0;
                        r_pairCnt <= '0;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + TIMEOUT_W'(1);
                    end
                end
                S_WAIT_Y: begin
                    if (conv.convDone) begin
                        if (w_lastPair) begin
                            r_xCoord     <= w_avgX;
                            r_yCoord     <= w_avgY;
                            r_coordValid <= 1'b1;
                            r_accX       <= '0;
                            r_accY       <= '0;
                        end else begin
                            r_accY <= w_sumY;
                        end
                    end else if (w_timeout) begin
                        r_convErr <= 1'b1;
                        r_penDown <= 1'b0;
                        r_accX    <= '0;
                        r_accY    <= '0;
                        r_pairCnt <= '0;
                    end else begin
                        r_timeoutCnt <= r_timeoutCnt + TIMEOUT_W'(1);
                    end
                end
                S_ROUND_END: begin
                    if (w_lastPair) r_pairCnt <= '0;
                    else            r_pairCnt <= r_pairCnt + PAIR_W'(1);
                    if (!w_penS) begin
                        r_penDown <= 1'b0;
                        r_accX    <= '0;
                        r_accY    <= '0;
                        r_pairCnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_scan_sched.sv
// Self-checking bench for touch_scan_sched: the bench plays the conversion
// engine, drives the pen interrupt, and checks averaged coordinates, timing
// and abort behaviour against hand-computed tables and an arithmetic model.
module tb_touch_scan_sched;

    localparam int AVG_LOG2 = 2;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 16;
    localparam int PAIRS    = 1 << AVG_LOG2;

    typedef logic [PAIRS-1:0][11:0] samples_t;

    typedef struct {
        samples_t    xs;
        samples_t    ys;
        logic [11:0] expX;
        logic [11:0] expY;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        penIrqN;
    logic [11:0] xCoord;
    logic [11:0] yCoord;
    logic        coordValid;
    logic        penDown;
    logic        convErr;

    int checks     = 0;
    int failures   = 0;
    int validCount = 0;
    int errCount   = 0;
    int startCount = 0;

    logic [11:0] modelX = 12'd0;
    logic [11:0] modelY = 12'd0;

    vec_t tbl [5];

    touch_scan_sched_if convBus ();

    touch_scan_sched #(
        .AVG_LOG2      (AVG_LOG2),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_penIrqN   (penIrqN),
        .conv        (convBus),
        .o_xCoord    (xCoord),
        .o_yCoord    (yCoord),
        .o_coordValid(coordValid),
        .o_penDown   (penDown),
        .o_convErr   (convErr)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge, clear of the negedge checks.
    always @(posedge clk) begin
        #3;
        if (coordValid)        validCount++;
        if (convErr)           errCount++;
        if (convBus.convStart) startCount++;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pen, input logic done, input logic [11:0] data);
        penIrqN          = pen;
        convBus.convDone = done;
        convBus.convData = data;
    endtask

    function automatic logic [11:0] avgOf(input samples_t s);
        int sum = 0;
        for (int i = 0; i < PAIRS; i++) sum += int'(s[i]);
        return 12'(sum / PAIRS);
    endfunction

    // Wait (bounded) for a request, then check its channel and the pen status.
    task automatic waitStart(input int expCh, input string tag);
        int n = 0;
        while (!convBus.convStart && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("%s start seen", tag), int'(convBus.convStart), 1);
        checkOutput($sformatf("%s channel", tag), int'(convBus.convCh), expCh);
        checkOutput($sformatf("%s pen down", tag), int'(penDown), 1);
    endtask

    // Answer one request after 'delay' wait cycles.
    task automatic serve(input int expCh, input logic [11:0] data, input int delay, input string tag);
        waitStart(expCh, tag);
        @(negedge clk);
        checkOutput($sformatf("%s start width", tag), int'(convBus.convStart), 0);
        repeat (delay) @(negedge clk);
        applyStimulus(penIrqN, 1'b1, data);
        @(negedge clk);
        applyStimulus(penIrqN, 1'b0, 12'd0);
    endtask

    // One complete round with the pen held; checks result latency and the next request.
    task automatic runRound(input samples_t xs, input samples_t ys, input logic [11:0] expX,
                            input logic [11:0] expY, input int maxDelay, input string tag);
        for (int i = 0; i < PAIRS; i++) begin
            serve(0, xs[i], int'($urandom_range(0, maxDelay)), $sformatf("%s x%0d", tag, i));
            serve(1, ys[i], int'($urandom_range(0, maxDelay)), $sformatf("%s y%0d", tag, i));
        end
        modelX = expX;
        modelY = expY;
        checkOutput($sformatf("%s valid latency", tag), int'(coordValid), 1);
        checkOutput($sformatf("%s x coord", tag), int'(xCoord), int'(modelX));
        checkOutput($sformatf("%s y coord", tag), int'(yCoord), int'(modelY));
        @(negedge clk);
        checkOutput($sformatf("%s valid width", tag), int'(coordValid), 0);
        checkOutput($sformatf("%s next start", tag), int'(convBus.convStart), 1);
        checkOutput($sformatf("%s next channel", tag), int'(convBus.convCh), 0);
    endtask

    initial begin
        int          snapValid;
        int          snapStart;
        int          snapErr;
        int          firstErr;
        int          n;
        samples_t    rx;
        samples_t    ry;

        tbl[0].xs = {12'd103, 12'd102, 12'd101, 12'd100};
        tbl[0].ys = {12'd212, 12'd208, 12'd204, 12'd200};
        tbl[0].expX = 12'd101;  tbl[0].expY = 12'd206;
        tbl[1].xs = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        tbl[1].ys = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
        tbl[1].expX = 12'd4095; tbl[1].expY = 12'd4095;
        tbl[2].xs = {12'd3, 12'd0, 12'd0, 12'd0};
        tbl[2].ys = {12'd0, 12'd1, 12'd1, 12'd1};
        tbl[2].expX = 12'd0;    tbl[2].expY = 12'd0;
        tbl[3].xs = {12'd0, 12'd0, 12'd0, 12'd4095};
        tbl[3].ys = {12'd41, 12'd30, 12'd20, 12'd10};
        tbl[3].expX = 12'd1023; tbl[3].expY = 12'd25;
        tbl[4].xs = {12'd7, 12'd7, 12'd7, 12'd7};
        tbl[4].ys = {12'd4095, 12'd4095, 12'd4095, 12'd4094};
        tbl[4].expX = 12'd7;    tbl[4].expY = 12'd4094;

        // Reset state.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'd0);
        repeat (3) @(negedge clk);
        checkOutput("reset pen_down", int'(penDown), 0);
        checkOutput("reset conv_start", int'(convBus.convStart), 0);
        checkOutput("reset conv_ch", int'(convBus.convCh), 0);
        checkOutput("reset coord_valid", int'(coordValid), 0);
        checkOutput("reset conv_err", int'(convErr), 0);
        checkOutput("reset x_coord", int'(xCoord), 0);
        checkOutput("reset y_coord", int'(yCoord), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Short pen glitch must not start a scan.
        snapStart = startCount;
        applyStimulus(1'b0, 1'b0, 12'd0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 12'd0);
        repeat (20) @(negedge clk);
        checkOutput("glitch no start", startCount - snapStart, 0);
        checkOutput("glitch pen_down", int'(penDown), 0);

        // Table of fixed rounds with the pen held.
        applyStimulus(1'b0, 1'b0, 12'd0);
        for (int i = 0; i < 5; i++) begin
            runRound(tbl[i].xs, tbl[i].ys, tbl[i].expX, tbl[i].expY, 2, $sformatf("tbl%0d", i));
        end

        // Randomized rounds checked against the averaging model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < PAIRS; i++) begin
                rx[i] = 12'($urandom_range(0, 4095));
                ry[i] = 12'($urandom_range(0, 4095));
            end
            runRound(rx, ry, avgOf(rx), avgOf(ry), 5, $sformatf("rnd%0d", r));
        end

        // Release during the second pair: the partial round is discarded.
        serve(0, 12'd11, 1, "rel x0");
        serve(1, 12'd22, 0, "rel y0");
        serve(0, 12'd33, 2, "rel x1");
        applyStimulus(1'b1, 1'b0, 12'd0);
        serve(1, 12'd44, 3, "rel y1");
        checkOutput("release no valid", int'(coordValid), 0);
        snapValid = validCount;
        snapStart = startCount;
        repeat (20) @(negedge clk);
        checkOutput("release no start", startCount - snapStart, 0);
        checkOutput("release no later valid", validCount - snapValid, 0);
        checkOutput("release pen_down", int'(penDown), 0);
        checkOutput("release x hold", int'(xCoord), int'(modelX));
        checkOutput("release y hold", int'(yCoord), int'(modelY));

        // Conversion timeout in WAIT_Y.
        applyStimulus(1'b0, 1'b0, 12'd0);
        serve(0, 12'd500, 1, "tmo x");
        waitStart(1, "tmo y");
        applyStimulus(1'b1, 1'b0, 12'd0);
        snapErr  = errCount;
        firstErr = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (convErr && firstErr < 0) begin
                firstErr = k;
                checkOutput("timeout pen_down", int'(penDown), 0);
            end
        end
        checkOutput("timeout err cycle", firstErr, TIMEOUT + 1);
        checkOutput("timeout err pulses", errCount - snapErr, 1);
        snapValid = validCount;
        snapStart = startCount;
        applyStimulus(1'b1, 1'b1, 12'd777);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 12'd0);
        repeat (10) @(negedge clk);
        checkOutput("stray done no valid", validCount - snapValid, 0);
        checkOutput("stray done no start", startCount - snapStart, 0);
        checkOutput("timeout x hold", int'(xCoord), int'(modelX));
        checkOutput("timeout y hold", int'(yCoord), int'(modelY));

        // Accumulators must start clean after the timeout.
        applyStimulus(1'b0, 1'b0, 12'd0);
        for (int i = 0; i < PAIRS; i++) begin
            rx[i] = 12'($urandom_range(0, 4095));
            ry[i] = 12'($urandom_range(0, 4095));
        end
        runRound(rx, ry, avgOf(rx), avgOf(ry), 3, "post tmo");

        // Reset while in WAIT_X clears everything at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst pen_down", int'(penDown), 0);
        checkOutput("midrst conv_start", int'(convBus.convStart), 0);
        checkOutput("midrst coord_valid", int'(coordValid), 0);
        checkOutput("midrst conv_err", int'(convErr), 0);
        checkOutput("midrst x_coord", int'(xCoord), 0);
        checkOutput("midrst y_coord", int'(yCoord), 0);
        modelX = 12'd0;
        modelY = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 12'd999);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 12'd0);
        n = 2;
        while (!convBus.convStart && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midrst debounce restart", int'(n >= SETTLE + 1 && n <= SETTLE + 4), 1);
        runRound(tbl[0].xs, tbl[0].ys, tbl[0].expX, tbl[0].expY, 1, "post rst");

        applyStimulus(1'b1, 1'b0, 12'd0);
        repeat (30) @(negedge clk);
        checkOutput("final pen_down", int'(penDown), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
